// File: rtl/text_pkg.sv
// Shared definitions for the text-mode cursor writer: screen geometry,
// control codes and the writer state encoding.
package text_pkg;

  localparam int DEFAULT_COLS = 80;
  localparam int DEFAULT_ROWS = 30;
  localparam int CELLS        = DEFAULT_ROWS * DEFAULT_COLS;
  localparam int ADDR_W       = 12;
  localparam int COL_W        = 7;
  localparam int ROW_W        = 5;

  localparam logic [7:0] CR       = 8'h0D;
  localparam logic [7:0] LF       = 8'h0A;
  localparam logic [7:0] BS       = 8'h08;
  localparam logic [7:0] FF       = 8'h0C;
  localparam logic [7:0] SPACE    = 8'h20;
  localparam logic [7:0] PRINT_LO = 8'h20;
  localparam logic [7:0] PRINT_HI = 8'h7E;

  typedef enum logic [1:0] {
    CLEAR_ALL = 2'd0,
    IDLE      = 2'd1,
    CLEAR_ROW = 2'd2
  } state_t;

  // True for bytes that are drawn as glyphs rather than interpreted.
  function automatic logic is_printable(input logic [7:0] b);
    return (b >= PRINT_LO) && (b <= PRINT_HI);
  endfunction

endpackage

// File: rtl/text_clear_sweep.sv
// Address generator for the clear sweeps: walks from a start address for a
// given number of cells, one address per step. Comes out of reset already
// loaded with a full-screen sweep so the power-up clear needs no start pulse.
module text_clear_sweep
  import text_pkg::*;
#(
  parameter int RESET_LEN = CELLS
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] length,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic              done
);

  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W-1:0] remain_reg;

  // Load a new sweep on start, otherwise advance while cells remain.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      addr_reg   <= '0;
      remain_reg <= ADDR_W'(RESET_LEN);
    end else if (start) begin
      addr_reg   <= start_addr;
      remain_reg <= length;
    end else if (step && (remain_reg != '0)) begin
      addr_reg   <= addr_reg + ADDR_W'(1);
      remain_reg <= remain_reg - ADDR_W'(1);
    end
  end

  assign addr = addr_reg;
  assign done = (remain_reg == '0);

endmodule

// File: rtl/text_cursor_writer.sv
// Turns a stream of received ASCII bytes into text-RAM writes with a
// cursor: printables are drawn and advance the cursor, CR/LF/BS/FF move it,
// and row advances or form feeds blank the affected cells with spaces.
module text_cursor_writer
  import text_pkg::*;
#(
  parameter int COLS = DEFAULT_COLS,
  parameter int ROWS = DEFAULT_ROWS
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic [COL_W-1:0]  cursor_col,
  output logic [ROW_W-1:0]  cursor_row,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] NUM_CELLS = ADDR_W'(ROWS * COLS);
  localparam logic [ADDR_W-1:0] ROW_LEN   = ADDR_W'(COLS);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(ROWS - 1);

  state_t            state_reg;
  logic [COL_W-1:0]  col_reg;
  logic [ROW_W-1:0]  row_reg;
  logic              wr_en_reg;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [7:0]        wr_data_reg;

  logic              accept;
  logic [ADDR_W-1:0] cur_addr;
  logic [ROW_W-1:0]  row_adv;
  logic              sweep_start;
  logic [ADDR_W-1:0] sweep_base;
  logic [ADDR_W-1:0] sweep_len;
  logic [ADDR_W-1:0] sweep_addr;
  logic              sweep_done;

  assign rx_ready = (state_reg == IDLE);
  assign busy     = (state_reg != IDLE);
  assign accept   = rx_valid && rx_ready;
  assign cur_addr = ADDR_W'(row_reg) * ROW_LEN + ADDR_W'(col_reg);
  assign row_adv  = (row_reg == LAST_ROW) ? '0 : row_reg + ROW_W'(1);

  // Decide whether the accepted byte launches a new clear sweep and where.
  always_comb begin
    sweep_start = 1'b0;
    sweep_base  = '0;
    sweep_len   = ROW_LEN;
    if (accept) begin
      if (rx_data == FF) begin
        sweep_start = 1'b1;
        sweep_len   = NUM_CELLS;
      end else if ((rx_data == LF) ||
                   (is_printable(rx_data) && (col_reg == LAST_COL))) begin
        sweep_start = 1'b1;
        sweep_base  = ADDR_W'(row_adv) * ROW_LEN;
      end
    end
  end

  text_clear_sweep #(
    .RESET_LEN (ROWS * COLS)
  ) u_sweep (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .start      (sweep_start),
    .start_addr (sweep_base),
    .length     (sweep_len),
    .step       (busy),
    .addr       (sweep_addr),
    .done       (sweep_done)
  );

  // Cursor, state and registered write port; the write and the cursor move
  // land on the same edge so the two are always consistent.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_reg   <= CLEAR_ALL;
      col_reg     <= '0;
      row_reg     <= '0;
      wr_en_reg   <= 1'b0;
      wr_addr_reg <= '0;
      wr_data_reg <= SPACE;
    end else begin
      wr_en_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            if (is_printable(rx_data)) begin
              wr_en_reg   <= 1'b1;
              wr_addr_reg <= cur_addr;
              wr_data_reg <= rx_data;
              if (col_reg == LAST_COL) begin
                col_reg   <= '0;
                row_reg   <= row_adv;
                state_reg <= CLEAR_ROW;
              end else begin
                col_reg <= col_reg + COL_W'(1);
              end
            end else begin
              case (rx_data)
                CR: col_reg <= '0;
                LF: begin
                  col_reg   <= '0;
                  row_reg   <= row_adv;
                  state_reg <= CLEAR_ROW;
                end
                BS: begin
                  if (col_reg != '0) begin
                    col_reg     <= col_reg - COL_W'(1);
                    wr_en_reg   <= 1'b1;
                    wr_addr_reg <= cur_addr - ADDR_W'(1);
                    wr_data_reg <= SPACE;
                  end
                end
                FF: begin
                  col_reg   <= '0;
                  row_reg   <= '0;
                  state_reg <= CLEAR_ALL;
                end
                default: ;
              endcase
            end
          end
        end
        default: begin
          // Both clear states: emit one blank per cycle until the sweep ends.
          if (sweep_done) begin
            state_reg <= IDLE;
          end else begin
            wr_en_reg   <= 1'b1;
            wr_addr_reg <= sweep_addr;
            wr_data_reg <= SPACE;
          end
        end
      endcase
    end
  end

  assign wr_en      = wr_en_reg;
  assign wr_addr    = wr_addr_reg;
  assign wr_data    = wr_data_reg;
  assign cursor_col = col_reg;
  assign cursor_row = row_reg;

endmodule

// File: tb/tb_text_cursor_writer.sv
// Randomized bench for text_cursor_writer against a cursor/screen model.
module tb_text_cursor_writer;

  localparam int COLS  = 80;
  localparam int ROWS  = 30;
  localparam int CELLS = COLS * ROWS;
  localparam int BOUND = 3000;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [7:0]  wr_data;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic        busy;

  text_cursor_writer #(.COLS(COLS), .ROWS(ROWS)) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .busy       (busy)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [19:0] mon_q[$];
  logic [19:0] exp_q[$];
  int cyc = 0;
  int last_wr_cyc = -10;
  int wr_busy_low = 0;
  int addr_bad = 0;
  int rdy_bad = 0;
  int m_col = 0;
  int m_row = 0;
  int txn = 0;
  int ff_left = 2;

  // Observe every write and the ready/busy relationship on the falling edge.
  always @(negedge Clk) begin
    cyc++;
    if (Rst_n) begin
      if (rx_ready == busy) rdy_bad++;
      if (wr_en) begin
        mon_q.push_back({wr_addr, wr_data});
        last_wr_cyc = cyc;
        if (!busy) wr_busy_low++;
        if (wr_addr >= 12'(CELLS)) addr_bad++;
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_advance();
    m_row = (m_row == ROWS - 1) ? 0 : m_row + 1;
    for (int c = 0; c < COLS; c++) exp_q.push_back({12'(m_row * COLS + c), 8'h20});
  endtask

  task automatic compare_writes(input string tag);
    int e;
    check_val({tag, "_nwr"}, mon_q.size(), exp_q.size());
    for (int i = 0; i < mon_q.size() && i < exp_q.size(); i++) begin
      e = n_errors;
      check_val({tag, "_wr"}, mon_q[i], exp_q[i]);
      if (n_errors != e) break;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_wr_en"}, wr_en, 0);
    check_val({tag, "_wr_addr"}, wr_addr, 0);
    check_val({tag, "_wr_data"}, wr_data, 8'h20);
    check_val({tag, "_col"}, cursor_col, 0);
    check_val({tag, "_row"}, cursor_row, 0);
    check_val({tag, "_rx_ready"}, rx_ready, 0);
  endtask

  // Called right after reset release: the full blank sweep must precede ready.
  task automatic check_reset_sweep(input string tag);
    int low0;
    mon_q.delete();
    exp_q.delete();
    for (int a = 0; a < CELLS; a++) exp_q.push_back({12'(a), 8'h20});
    low0 = wr_busy_low;
    for (int k = 0; k < BOUND; k++) begin
      @(negedge Clk); #1;
      if (rx_ready) break;
    end
    check_val({tag, "_ready"}, rx_ready, 1);
    compare_writes(tag);
    check_val({tag, "_busy_low"}, wr_busy_low - low0, 0);
    check_val({tag, "_ready_lat"}, cyc - last_wr_cyc, 1);
    check_val({tag, "_col"}, cursor_col, 0);
    check_val({tag, "_row"}, cursor_row, 0);
    $display("txn %0d reset sweep %s: %0d writes", txn, tag, mon_q.size());
    txn++;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic hold);
    logic imm;
    exp_q.delete();
    imm = 1'b0;
    if (b >= 8'h20 && b <= 8'h7E) begin
      exp_q.push_back({12'(m_row * COLS + m_col), b});
      imm = 1'b1;
      m_col++;
      if (m_col == COLS) begin
        m_col = 0;
        model_advance();
      end
    end else if (b == 8'h0D) begin
      m_col = 0;
    end else if (b == 8'h0A) begin
      m_col = 0;
      model_advance();
    end else if (b == 8'h08) begin
      if (m_col > 0) begin
        m_col--;
        exp_q.push_back({12'(m_row * COLS + m_col), 8'h20});
        imm = 1'b1;
      end
    end else if (b == 8'h0C) begin
      m_col = 0;
      m_row = 0;
      for (int a = 0; a < CELLS; a++) exp_q.push_back({12'(a), 8'h20});
    end

    for (int k = 0; k < BOUND && !rx_ready; k++) begin
      @(negedge Clk); #1;
    end
    check_val("pre_ready", rx_ready, 1);
    mon_q.delete();
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge Clk); #1;
    rx_valid = 1'b0;
    check_val("imm_col", cursor_col, m_col);
    check_val("imm_row", cursor_row, m_row);
    check_val("imm_wr_en", wr_en, imm);

    // While the writer is busy, optionally offer a junk byte it must refuse.
    for (int k = 0; k < BOUND; k++) begin
      @(negedge Clk); #1;
      if (rx_ready) begin
        rx_valid = 1'b0;
        break;
      end
      if (hold) begin
        rx_data  = 8'h23;
        rx_valid = 1'b1;
      end
    end
    rx_valid = 1'b0;
    check_val("post_ready", rx_ready, 1);
    compare_writes("txn");
    $display("txn %0d byte %02h -> cursor (%0d,%0d) writes %0d",
             txn, b, cursor_col, cursor_row, mon_q.size());
    txn++;
  endtask

  initial begin
    logic [7:0] b;
    int unsigned r;

    // Reset values while held, then the power-up sweep.
    #23;
    check_reset_outputs("rst");
    @(negedge Clk);
    Rst_n = 1'b1;
    check_reset_sweep("pwr_sweep");

    // First character lands at cell 0, cursor moves to column 1.
    send_byte(8'h41, 1'b0);
    check_val("A_addr", wr_addr, 0);
    check_val("A_data", wr_data, 8'h41);

    // Backspace from column 5 down to column 0, then once more at column 0.
    for (int i = 0; i < 4; i++) send_byte(8'h42 + 8'(i), 1'b0);
    for (int i = 0; i < 6; i++) send_byte(8'h08, 1'b1);
    check_val("bs_col0_nwr", mon_q.size(), 0);

    // Fill row 0 and wrap off column 79.
    for (int i = 0; i < COLS; i++) send_byte(8'($urandom_range(32, 126)), 1'b1);
    check_val("wrap_row", cursor_row, 1);

    // Line feeds down to row 29, then one more wraps to row 0.
    for (int i = 0; i < ROWS - 1; i++) send_byte(8'h0A, 1'b1);
    check_val("lf_wrap_row", cursor_row, 0);

    // Random traffic.
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 99);
      if (r < 62) b = 8'($urandom_range(32, 126));
      else if (r < 70) b = 8'h0D;
      else if (r < 78) b = 8'h0A;
      else if (r < 88) b = 8'h08;
      else if (r < 90 && ff_left > 0) begin
        b = 8'h0C;
        ff_left--;
      end else begin
        case ($urandom_range(0, 3))
          0: b = 8'h00;
          1: b = 8'h1B;
          2: b = 8'h7F;
          default: b = 8'($urandom_range(128, 255));
        endcase
      end
      send_byte(b, 1'($urandom_range(0, 1)));
    end

    // Reset pulled in the middle of a row clear.
    rx_data  = 8'h0A;
    rx_valid = 1'b1;
    @(posedge Clk); #1;
    rx_valid = 1'b0;
    check_val("mid_busy", busy, 1);
    repeat (10) @(negedge Clk);
    #2 Rst_n = 1'b0;
    #1 check_reset_outputs("mid_rst");
    m_col = 0;
    m_row = 0;
    repeat (3) @(negedge Clk);
    Rst_n = 1'b1;
    check_reset_sweep("re_sweep");
    send_byte(8'h5A, 1'b0);
    send_byte(8'h0D, 1'b0);

    check_val("addr_range", addr_bad, 0);
    check_val("ready_vs_busy", rdy_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
